// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern colour stage sitting after the VGA timing
// generator. It has a two-stage pipeline (position/sync, then colour/sync)
// and a button-driven pattern mode that changes only at frame boundaries.
// Optional build macro: VGA_PATTERN_BOX_EN adds the bouncing-box pattern
// (mode 2) and its position/velocity registers.
module vga_pattern_gen #(
  parameter int          H_OFFSET  = 160,
  parameter int          V_OFFSET  = 41,
  parameter int          BOX_SIZE  = 32,
  parameter int          BOX_STEP  = 2,
  parameter logic [11:0] SOLID_RGB = 12'h00F
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       bright,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       btn,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       h_sync_o,
  output logic       v_sync_o,
  output logic [1:0] mode
);

  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_BOX     = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  localparam logic [10:0] H_FIRST = 11'(H_OFFSET);
  localparam logic [10:0] H_LAST  = 11'(H_OFFSET + 639);

  // ---------------- stage 1: position, active flag, syncs ----------------
  logic [9:0] x_d, y_d, x_q, y_q;
  logic       act_d, act_q;
  logic       hs1_q, vs1_q;

  // Screen coordinates and active-pixel qualification from the raw counters.
  always_comb begin
    x_d   = h_count - 10'(H_OFFSET);
    y_d   = v_count - 10'(V_OFFSET);
    act_d = bright && ({1'b0, h_count} >= H_FIRST) && ({1'b0, h_count} <= H_LAST);
  end

  // Stage-1 pipeline registers; syncs idle high.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      hs1_q <= h_sync;
      vs1_q <= v_sync;
    end
  end

  // ---------------- button synchroniser and mode control ----------------
  logic btn_meta_q, btn_sync_q, btn_prev_q;
  logic btn_rise, frame_tick;
  logic [1:0] mode_q, mode_d, pend_q, pend_d;
  logic       hs2_q, vs2_q;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign btn_rise = btn_sync_q & ~btn_prev_q;
  // vs2_q holds the previous value of the registered v_sync, so this fires
  // once on its falling edge.
  assign frame_tick = vs2_q & ~vs1_q;

  function automatic logic [1:0] mode_next(input logic [1:0] m);
`ifdef VGA_PATTERN_BOX_EN
    return m + 2'd1;
`else
    case (m)
      MODE_BARS:    return MODE_CHECKER;
      MODE_CHECKER: return MODE_SOLID;
      default:      return MODE_BARS;
    endcase
`endif
  endfunction

  // Button edges advance the pending mode; the live mode only takes it at a
  // frame tick. Both can happen in one cycle: mode takes the old pending.
  always_comb begin
    pend_d = btn_rise   ? mode_next(pend_q) : pend_q;
    mode_d = frame_tick ? pend_q            : mode_q;
  end

  // Mode registers.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= MODE_BARS;
      mode_q <= MODE_BARS;
    end else begin
      pend_q <= pend_d;
      mode_q <= mode_d;
    end
  end

`ifdef VGA_PATTERN_BOX_EN
  // ---------------- bouncing box ----------------
  localparam logic [9:0] STEP10 = 10'(BOX_STEP);
  localparam logic [9:0] X_MAX  = 10'(640 - BOX_SIZE - 1);
  localparam logic [9:0] Y_MAX  = 10'(480 - BOX_SIZE - 1);

  logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic       dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic       in_box;

  // One axis step: returns {negative_direction, new_position}, clamping at
  // 0 / lim and reversing direction when a move would leave the range.
  function automatic logic [10:0] box_step(input logic [9:0] pos, input logic neg,
                                           input logic [9:0] lim);
    logic [10:0] up;
    up = {1'b0, pos} + {1'b0, STEP10};
    if (neg) begin
      if (pos < STEP10) return {1'b0, 10'd0};
      else              return {1'b1, pos - STEP10};
    end else begin
      if (up > {1'b0, lim}) return {1'b1, lim};
      else                  return {1'b0, up[9:0]};
    end
  endfunction

  // Box moves on every frame tick regardless of the displayed mode.
  always_comb begin
    {dx_neg_d, box_x_d} = {dx_neg_q, box_x_q};
    {dy_neg_d, box_y_d} = {dy_neg_q, box_y_q};
    if (frame_tick) begin
      {dx_neg_d, box_x_d} = box_step(box_x_q, dx_neg_q, X_MAX);
      {dy_neg_d, box_y_d} = box_step(box_y_q, dy_neg_q, Y_MAX);
    end
  end

  // Box position and velocity-sign registers.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      box_x_q  <= '0;
      box_y_q  <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
    end else begin
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
    end
  end

  assign in_box = ({1'b0, x_q} >= {1'b0, box_x_q}) &&
                  ({1'b0, x_q} <  {1'b0, box_x_q} + 11'(BOX_SIZE)) &&
                  ({1'b0, y_q} >= {1'b0, box_y_q}) &&
                  ({1'b0, y_q} <  {1'b0, box_y_q} + 11'(BOX_SIZE));
`else
  // Only y[5] feeds the checker pattern in this build.
  logic unused_y;
  assign unused_y = ^{y_q[9:6], y_q[4:0]};
`endif

  // ---------------- stage 2: colour ----------------
  logic [11:0] rgb_d, rgb_q;

  function automatic logic [11:0] bar_rgb(input logic [9:0] px);
    if      (px < 10'd80)  return 12'hFFF;
    else if (px < 10'd160) return 12'hFF0;
    else if (px < 10'd240) return 12'h0FF;
    else if (px < 10'd320) return 12'h0F0;
    else if (px < 10'd400) return 12'hF0F;
    else if (px < 10'd480) return 12'hF00;
    else if (px < 10'd560) return 12'h00F;
    else                   return 12'h000;
  endfunction

  // Pattern colour for the stage-1 pixel; black outside the active area.
  always_comb begin
    rgb_d = 12'h000;
    if (act_q) begin
      case (mode_q)
        MODE_BARS:    rgb_d = bar_rgb(x_q);
        MODE_CHECKER: rgb_d = (x_q[5] ^ y_q[5]) ? 12'hFFF : 12'h000;
`ifdef VGA_PATTERN_BOX_EN
        MODE_BOX:     rgb_d = in_box ? 12'hFF0 : 12'h000;
`endif
        MODE_SOLID:   rgb_d = SOLID_RGB;
        default:      rgb_d = 12'h000;
      endcase
    end
  end

  // Stage-2 registers: colour and syncs leave the block aligned.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= 12'h000;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign h_sync_o = hs2_q;
  assign v_sync_o = vs2_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed steps, expected pixels queued at drive
// time and compared when they leave the 2-stage pipeline.
module tb_vga_pattern_gen;
  logic       clk_25 = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] h_count, v_count;
  logic       bright, h_sync, v_sync, btn;
  logic [3:0] red, green, blue;
  logic       h_sync_o, v_sync_o;
  logic [1:0] mode;

  vga_pattern_gen dut (
    .clk_25(clk_25), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .bright(bright), .h_sync(h_sync), .v_sync(v_sync), .btn(btn),
    .red(red), .green(green), .blue(blue),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .mode(mode)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [11:0] bars_tbl [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [1:0] exp_mode = 2'd0;
  logic [1:0] exp_pend = 2'd0;
`ifdef VGA_PATTERN_BOX_EN
  int bx = 0, by = 0, vx = 2, vy = 2;
`endif

  initial forever begin
    @(posedge clk_25);
    cyc++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compare the entry whose output cycle has arrived.
  initial forever begin
    @(negedge clk_25);
    if (reset_n && sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_rgb"}, {4'h0, red, green, blue}, {4'h0, e.rgb});
      chk({e.tag, "_sync"}, {14'h0, h_sync_o, v_sync_o}, {14'h0, e.hs, e.vs});
    end
  end

  function automatic logic [1:0] mode_nxt(input logic [1:0] m);
`ifdef VGA_PATTERN_BOX_EN
    return (m == 2'd3) ? 2'd0 : m + 2'd1;
`else
    return (m == 2'd0) ? 2'd1 : (m == 2'd1) ? 2'd3 : 2'd0;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic b);
    int x, y;
    x = h - 160;
    y = v - 41;
    if (!b || x < 0 || x > 639) return 12'h000;
    case (exp_mode)
      2'd0: return bars_tbl[x / 80];
      2'd1: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
`ifdef VGA_PATTERN_BOX_EN
      2'd2: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 12'hFF0 : 12'h000;
`endif
      default: return 12'h00F;
    endcase
  endfunction

  task automatic model_reset();
    exp_mode = 2'd0;
    exp_pend = 2'd0;
`ifdef VGA_PATTERN_BOX_EN
    bx = 0; by = 0; vx = 2; vy = 2;
`endif
  endtask

  task automatic drv(input int h, input int v, input logic b, input logic hs,
                     input logic vs, input bit push, input string tag);
    @(posedge clk_25);
    #1;
    h_count = 10'(h);
    v_count = 10'(v);
    bright  = b;
    h_sync  = hs;
    v_sync  = vs;
    if (push) sb.push_back('{due: cyc + 2, rgb: model_rgb(h, v, b), hs: hs, vs: vs, tag: tag});
  endtask

  task automatic pix(input int x, input int y, input string tag);
    drv(x + 160, y + 41, 1'b1, 1'b1, 1'b1, 1'b1, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, "");
  endtask

  // Short synthetic vertical sync; the DUT ticks on its falling edge.
  task automatic vsync_pulse();
    drv(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, "vs_low0");
    drv(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "vs_low1");
    idle(3);
    exp_mode = exp_pend;
`ifdef VGA_PATTERN_BOX_EN
    bx += vx;
    if (bx > 607) begin bx = 607; vx = -vx; end
    else if (bx < 0) begin bx = 0; vx = -vx; end
    by += vy;
    if (by > 447) begin by = 447; vy = -vy; end
    else if (by < 0) begin by = 0; vy = -vy; end
`endif
  endtask

  task automatic btn_pulse();
    btn = 1'b1;
    idle(3);
    btn = 1'b0;
    idle(3);
    exp_pend = mode_nxt(exp_pend);
  endtask

  task automatic do_reset();
    @(posedge clk_25);
    #5 reset_n = 1'b0;
    sb.delete();
    @(posedge clk_25);
    #5 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int xs[] = '{85, 639, 0, 79, 80, 160, 240, 320, 400, 480, 560};
    logic [1:0] old_pend;
    h_count = '0; v_count = '0; bright = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1; btn = 1'b0;

    // Power-on reset
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_25);
    #1;
    chk("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
    chk("rst_hs", {15'h0, h_sync_o}, 16'h1);
    chk("rst_vs", {15'h0, v_sync_o}, 16'h1);
    chk("rst_mode", {14'h0, mode}, 16'h0);
    @(negedge clk_25) reset_n = 1'b1;
    model_reset();
    idle(2);

    // BARS frame, bar boundaries and active-window edges
    foreach (xs[i]) pix(xs[i], 10, $sformatf("bars_x%0d", xs[i]));
    drv(159, 51, 1'b1, 1'b1, 1'b1, 1'b1, "left_of_active");
    drv(800, 51, 1'b1, 1'b1, 1'b1, 1'b1, "right_of_active");
    drv(245, 51, 1'b0, 1'b1, 1'b1, 1'b1, "not_bright");
    drv(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "hs_low");
    pix(85, 10, "bars_after_hs");
    idle(3);

    // One button pulse mid-frame: mode waits for the frame tick
    btn_pulse();
    chk("mode_hold1", {14'h0, mode}, {14'h0, exp_mode});
    pix(85, 10, "bars_pending");
    vsync_pulse();
    chk("mode_checker", {14'h0, mode}, {14'h0, exp_mode});
    pix(32, 0, "chk_32_0");
    pix(32, 32, "chk_32_32");
    pix(0, 0, "chk_0_0");
    pix(64, 32, "chk_64_32");

    // Asynchronous reset mid-line
    pix(32, 0, "pre_rst_a");
    pix(33, 0, "pre_rst_b");
    @(posedge clk_25);
    #10 reset_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_rgb", {4'h0, red, green, blue}, 16'h0000);
    chk("midrst_mode", {14'h0, mode}, 16'h0);
    chk("midrst_hs", {15'h0, h_sync_o}, 16'h1);
    chk("midrst_vs", {15'h0, v_sync_o}, 16'h1);
    @(posedge clk_25);
    #15 reset_n = 1'b1;
    model_reset();
    pix(85, 10, "post_rst_first");
    pix(200, 10, "post_rst_second");
    idle(3);

    // Three pulses in one frame: only the final pending value is applied
    btn_pulse(); btn_pulse(); btn_pulse();
    chk("mode_hold3", {14'h0, mode}, 16'h0);
    vsync_pulse();
`ifdef VGA_PATTERN_BOX_EN
    chk("mode_three", {14'h0, mode}, 16'h3);
`else
    chk("mode_three", {14'h0, mode}, 16'h0);
`endif
    pix(100, 100, "three_pix");
    pix(600, 400, "three_pix2");

    // Button edge landing on the frame-tick cycle
    old_pend = exp_pend;
    exp_pend = mode_nxt(old_pend);
    idle(1);
    btn = 1'b1;
    vsync_pulse();
    exp_mode = old_pend;
    btn = 1'b0;
    idle(3);
    chk("coinc_mode_old", {14'h0, mode}, {14'h0, old_pend});
    pix(300, 200, "coinc_pix");
    vsync_pulse();
    chk("coinc_mode_new", {14'h0, mode}, {14'h0, exp_pend});

    // Two pulses from reset
    do_reset();
    btn_pulse(); btn_pulse();
    vsync_pulse();
`ifdef VGA_PATTERN_BOX_EN
    chk("mode_box", {14'h0, mode}, 16'h2);
    pix(0, 0, "box_origin");
    begin
      int guard = 0;
      while (bx != 606 && guard < 400) begin
        vsync_pulse();
        guard++;
      end
    end
    chk("mode_box_still", {14'h0, mode}, 16'h2);
    pix(606, by, "box606_in");
    pix(605, by, "box606_left");
    pix(637, by, "box606_right_in");
    pix(638, by, "box606_right_out");
    pix(606, by + 32, "box606_below");
    vsync_pulse();
    pix(607, by, "box607_in");
    pix(606, by, "box607_left");
    vsync_pulse();
    pix(605, by, "box605_in");
    pix(604, by, "box605_left");
    pix(636, by, "box605_right_in");
    pix(637, by, "box605_right_out");
`else
    chk("mode_skip2", {14'h0, mode}, 16'h3);
    pix(50, 50, "solid_pix");
`endif

    idle(4);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low, named clk_25 and reset_n as in the rest of the VGA path.
REQ-002 The block SHALL have these parameters (name, default, meaning):
  H_OFFSET, 160, first active h_count
  V_OFFSET, 41, first active v_count
  BOX_SIZE, 32, box edge length in pixels
  BOX_STEP, 2, box move per frame in pixels
  SOLID_RGB, 12'h00F, colour in SOLID mode
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  clk_25  in  1  25 MHz pixel clock
  reset_n  in  1  async active-low reset
  h_count  in  10  horizontal counter from timing stage
  v_count  in  10  vertical counter from timing stage
  bright  in  1  vertical active flag from timing stage
  h_sync  in  1  horizontal sync from timing stage
  v_sync  in  1  vertical sync from timing stage
  btn  in  1  asynchronous mode-advance button, active-high
  red  out  4  pixel red
  green  out  4  pixel green
  blue  out  4  pixel blue
  h_sync_o  out  1  h_sync delayed to align with RGB
  v_sync_o  out  1  v_sync delayed to align with RGB
  mode  out  2  current pattern: 0 BARS, 1 CHECKER, 2 BOX, 3 SOLID

Function
REQ-004 Pixel active SHALL be: bright=1 and H_OFFSET <= h_count <= H_OFFSET+639; x = h_count-H_OFFSET (0..639) and y = v_count-V_OFFSET (0..479).
REQ-005 RGB and h_sync_o/v_sync_o SHALL have exactly 2 cycles of latency from the inputs: stage 1 registers x, y, active and the syncs; stage 2 registers the colour and the syncs.
REQ-006 When the pixel is not active, RGB SHALL be 12'h000.
REQ-007 BARS mode: bar = x/80; the colours for bars 0..7 SHALL be FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-008 CHECKER mode: colour SHALL be FFF when x[5]^y[5]=1, else 000.
REQ-009 SOLID mode: colour SHALL be SOLID_RGB.
REQ-010 btn SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal SHALL set pending_mode to the next mode in the sequence.
REQ-011 Frame tick SHALL be a 1->0 transition of the registered v_sync input; one tick per frame.
REQ-012 mode SHALL load pending_mode only on a frame tick, so a mode never changes mid-frame.
REQ-013 If there are multiple btn edges within one frame, each edge SHALL advance pending_mode once; only the final value is applied at the tick.
REQ-014 A btn edge coinciding with a frame tick SHALL advance pending_mode; mode loads the old pending_mode, and the new value applies at the next tick.

Reset
REQ-015 Asserting reset_n=0 SHALL immediately clear RGB to 000, set h_sync_o=v_sync_o=1, set mode=pending_mode=0 (BARS), and clear the synchroniser and pipeline flops.
REQ-016 Reset asserted mid-frame SHALL abort the current pixels; after release, the first valid RGB SHALL appear 2 cycles after the first active input.
REQ-017 Reset SHALL set the box state to box_x=0, box_y=0, dx=+BOX_STEP, dy=+BOX_STEP.

Configuration
REQ-018 Macro VGA_PATTERN_BOX_EN SHALL compile in the BOX mode and its registers.
REQ-019 With VGA_PATTERN_BOX_EN defined:
  mode sequence SHALL be 0->1->2->3->0.
  In BOX mode, the colour SHALL be FF0 inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE), and 000 elsewhere.
  On each frame tick, box_x+=dx and box_y+=dy.
  If the result exceeds 640-BOX_SIZE (608-1=607) or drops below 0, the position SHALL be clamped to the limit and the velocity sign negated.
  The box SHALL move on every tick, in every mode.
REQ-020 Without VGA_PATTERN_BOX_EN:
  mode sequence SHALL be 0->1->3->0.
  mode SHALL never equal 2.
  No box registers SHALL exist.

Verification
REQ-021 After reset, a full frame in BARS -> pixel x=85,y=10 is FF0 and x=639 is 000; RGB appears 2 clocks after the input and the syncs are aligned.
REQ-022 One btn pulse mid-frame -> mode stays 0 until the next v_sync fall, then becomes 1; x=32,y=0 is FFF and x=32,y=32 is 000.
REQ-023 Three btn pulses in one frame with VGA_PATTERN_BOX_EN defined -> mode becomes 3 at the tick, and RGB at an active pixel is 00F; without the macro, mode becomes 0.
REQ-024 BOX mode, box_x=606, dx=+2 -> after one tick box_x=607 and dx=-2; after the next tick box_x=605.
REQ-025 Assert reset_n=0 asynchronously mid-line -> RGB=000 and mode=0 within the same cycle; release -> normal output resumes within 2 cycles of active input.
